// File: rtl/adder_rr_arbiter.sv
`timescale 1ns/1ps
// adder_rr_arbiter
//
// Shares one W-bit adder (W+1-bit sum, carry kept in the MSB) between
// NUM_REQ requesters. A winner is picked in IDLE, and its operands are
// latched. The add happens in EXEC. The result is presented in DONE until
// the consumer accepts it with Valid_o & Ready_i.
//
// Build option:
//   ADDER_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest set index wins,
//                                         no rotation pointer
//                            undefined -> round-robin from a rotating pointer
//
// Ports:
//   clk         system clock, all state on rising edge
//   rst         asynchronous active-low reset
//   Req_i       per-requester level request
//   Data_A_i    packed operand A, slice k = [k*W +: W]
//   Data_B_i    packed operand B, same packing
//   Ack_o       one-hot pulse: operands of that requester were captured
//   Data_S_o    sum of the granted operands, carry in MSB
//   Grant_id_o  index of the requester that owns Data_S_o
//   Valid_o     Data_S_o / Grant_id_o valid
//   Ready_i     consumer accepts the result when Valid_o & Ready_i
module adder_rr_arbiter #(
    parameter int W       = 32,
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   Req_i,
    input  logic [NUM_REQ*W-1:0] Data_A_i,
    input  logic [NUM_REQ*W-1:0] Data_B_i,
    output logic [NUM_REQ-1:0]   Ack_o,
    output logic [W:0]           Data_S_o,
    output logic [ID_W-1:0]      Grant_id_o,
    output logic                 Valid_o,
    input  logic                 Ready_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [W-1:0]       op_a_reg, op_a_next;
    logic [W-1:0]       op_b_reg, op_b_next;
    logic [W:0]         sum_reg, sum_next;
    logic [ID_W-1:0]    gid_reg, gid_next;
    logic [NUM_REQ-1:0] ack_reg, ack_next;
    logic               valid_reg, valid_next;

`ifndef ADDER_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]    ptr_reg, ptr_next;
`endif

    // Unpack the operand buses so the winner can select its slice by index.
    logic [W-1:0] a_slice [NUM_REQ];
    logic [W-1:0] b_slice [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_slice[gi] = Data_A_i[gi*W +: W];
            assign b_slice[gi] = Data_B_i[gi*W +: W];
        end
    endgenerate

    // Winner search: visit candidates in priority order and keep the first
    // one that is requesting. In round-robin mode the order starts at the
    // pointer and wraps modulo NUM_REQ.
    logic            win_found;
    logic [ID_W-1:0] win_idx;
    logic [ID_W-1:0] cand_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
            cand_idx = ID_W'(i);
`else
            cand_idx = ID_W'((int'(ptr_reg) + i) % NUM_REQ);
`endif
            if (!win_found && Req_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_next = state_reg;
        op_a_next  = op_a_reg;
        op_b_next  = op_b_reg;
        sum_next   = sum_reg;
        gid_next   = gid_reg;
        ack_next   = '0;
        valid_next = valid_reg;
`ifndef ADDER_ARB_FIXED_PRIO_EN
        ptr_next   = ptr_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    op_a_next         = a_slice[win_idx];
                    op_b_next         = b_slice[win_idx];
                    gid_next          = win_idx;
                    ack_next[win_idx] = 1'b1;
`ifndef ADDER_ARB_FIXED_PRIO_EN
                    ptr_next = (win_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                               : win_idx + ID_W'(1);
`endif
                    state_next = EXEC;
                end
            end
            EXEC: begin
                // Zero-extend both operands so the carry lands in the MSB.
                sum_next   = {1'b0, op_a_reg} + {1'b0, op_b_reg};
                valid_next = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                if (Ready_i) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            sum_reg   <= '0;
            gid_reg   <= '0;
            ack_reg   <= '0;
            valid_reg <= 1'b0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
            ptr_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            op_a_reg  <= op_a_next;
            op_b_reg  <= op_b_next;
            sum_reg   <= sum_next;
            gid_reg   <= gid_next;
            ack_reg   <= ack_next;
            valid_reg <= valid_next;
`ifndef ADDER_ARB_FIXED_PRIO_EN
            ptr_reg   <= ptr_next;
`endif
        end
    end

    assign Ack_o      = ack_reg;
    assign Data_S_o   = sum_reg;
    assign Grant_id_o = gid_reg;
    assign Valid_o    = valid_reg;

endmodule
